// File: rtl/fft_frame_source_if.sv
// AXI4-Stream bundle between the frame source and the xfft slave config/data ports.
// A beat moves on any rising edge where tvalid && tready; the master holds tdata/tlast stable while tvalid && !tready.
interface fft_frame_source_if;
  logic [7:0]  cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [31:0] dat_tdata;
  logic        dat_tvalid;
  logic        dat_tready;
  logic        dat_tlast;

  modport master (
    output cfg_tdata, cfg_tvalid, dat_tdata, dat_tvalid, dat_tlast,
    input  cfg_tready, dat_tready
  );

  modport slave (
    input  cfg_tdata, cfg_tvalid, dat_tdata, dat_tvalid, dat_tlast,
    output cfg_tready, dat_tready
  );
endinterface

// File: rtl/fft_frame_source.sv
// Frame source for the xfft core: one config beat, then FFT_LEN offset-binary ADC
// samples converted to signed complex and streamed through a small FIFO.
module fft_frame_source #(
  parameter int FFT_LEN    = 1024,
  parameter int AD_WIDTH   = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic                fwd_inv,
  input  logic [AD_WIDTH-1:0] ad_data,
  input  logic                ad_valid,
  fft_frame_source_if.master  axis,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(FFT_LEN) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LEN     = CW'(FFT_LEN);
  localparam logic [CW-1:0] LAST    = CW'(FFT_LEN - 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                      state;
  logic [7:0]                  cfg_data_q;
  logic                        cfg_valid_q;
  logic [CW-1:0]               in_cnt;
  logic [CW-1:0]               out_cnt;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 fifo_cnt;
  logic [15:0]                 mem [FIFO_DEPTH];

  logic signed [AD_WIDTH-1:0]  sample_s;
  logic [15:0]                 sample_re;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        in_room;
  logic                        rd_en;
  logic                        wr_en;
  logic                        drop;
  logic                        last_beat;

  // Offset-binary to two's complement is an MSB flip; the signed cast sign-extends.
  assign sample_s  = {~ad_data[AD_WIDTH-1], ad_data[AD_WIDTH-2:0]};
  assign sample_re = 16'(sample_s);

  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_empty = (fifo_cnt == '0);
  assign rd_en      = !fifo_empty && axis.dat_tready;
  assign in_room    = (state == STREAM) && ad_valid && (in_cnt < LEN);
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign wr_en      = in_room && (!fifo_full || rd_en);
  assign drop       = in_room && fifo_full && !rd_en;
  assign last_beat  = rd_en && (out_cnt == LAST);

  assign axis.cfg_tdata  = cfg_data_q;
  assign axis.cfg_tvalid = cfg_valid_q;
  assign axis.dat_tvalid = !fifo_empty;
  assign axis.dat_tdata  = fifo_empty ? 32'h0 : {16'h0, mem[rd_ptr]};
  assign axis.dat_tlast  = !fifo_empty && (out_cnt == LAST);
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= sample_re;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cfg_data_q  <= 8'h00;
      cfg_valid_q <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;

      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        in_cnt <= in_cnt + 1'b1;
      end
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= out_cnt + 1'b1;
      end
      if (wr_en && !rd_en)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!wr_en && rd_en) fifo_cnt <= fifo_cnt - 1'b1;
      if (drop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            cfg_data_q  <= {7'b0, fwd_inv};
            cfg_valid_q <= 1'b1;
            overflow    <= 1'b0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            state       <= CFG;
          end
        end
        CFG: begin
          if (axis.cfg_tready) begin
            cfg_valid_q <= 1'b0;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (last_beat) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_frame_source.md
Name: fft_frame_source

Overview:
- AXI4-Stream transmitter that feeds the xfft core's slave config and data channels.
- Latches a forward/inverse selection, issues one config beat, then captures exactly FFT_LEN ADC samples.
- Converts each sample from offset-binary to signed complex, buffers it in a small FIFO and streams it with correct tvalid/tlast under tready backpressure.
- Sits between the ADC capture path and the FFT/IFFT core; one frame per start pulse.

Parameters:
FFT_LEN, 1024, samples per frame (power of two, 8..65536)
AD_WIDTH, 10, ADC sample width (offset-binary)
FIFO_DEPTH, 16, sample buffer depth (power of two, >=4)

Ports:
sys_clk  in  1  system/FFT clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin a frame (ignored unless IDLE)
fwd_inv  in  1  1 = forward FFT, 0 = inverse; sampled on accepted start
ad_data  in  AD_WIDTH  ADC sample, offset-binary
ad_valid  in  1  ad_data valid this cycle
cfg_tdata  out  8  to s_axis_config_tdata
cfg_tvalid  out  1  to s_axis_config_tvalid
cfg_tready  in  1  from s_axis_config_tready
dat_tdata  out  32  to s_axis_data_tdata, {imag[15:0], real[15:0]}
dat_tvalid  out  1  to s_axis_data_tvalid
dat_tready  in  1  from s_axis_data_tready
dat_tlast  out  1  to s_axis_data_tlast
busy  out  1  high in CFG/STREAM/DONE
frame_done  out  1  one-cycle pulse when last beat handshakes
overflow  out  1  sticky: a sample was dropped in the current frame

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters, FIFO pointers and cfg register cleared.
- FSM IDLE -> CFG on start. Latch cfg_tdata = {7'b0, fwd_inv}. Clear overflow and both counters.
- CFG: cfg_tvalid=1 and cfg_tdata held stable until cfg_tvalid && cfg_tready. Next cycle -> STREAM, cfg_tvalid=0.
- Sample capture in STREAM only:
  - A sample is accepted when ad_valid=1, in_cnt < FFT_LEN and the FIFO is not full. in_cnt increments on each accepted sample.
  - ad_valid with FIFO full and in_cnt < FFT_LEN: sample dropped, overflow<=1, in_cnt unchanged.
  - ad_valid outside STREAM, or once in_cnt = FFT_LEN: ignored, no overflow.
- Conversion: real = sign-extend of {~ad_data[AD_WIDTH-1], ad_data[AD_WIDTH-2:0]} to 16 bits; imag = 0. Example: 10'h3FF -> 16'h01FF, 10'h000 -> 16'hFE00, 10'h200 -> 16'h0000.
- Output path:
  - dat_tvalid = FIFO non-empty (registered FIFO head); dat_tdata is the FIFO head.
  - A beat transfers on dat_tvalid && dat_tready; out_cnt increments on each transfer.
  - dat_tdata and dat_tlast must stay stable while dat_tvalid && !dat_tready.
  - dat_tlast=1 exactly on the beat with out_cnt = FFT_LEN-1.
  - Minimum latency is 1 cycle from an accepted sample to dat_tvalid.
- A FIFO write and a FIFO read in the same cycle are both allowed when full; the count is unchanged and nothing is dropped.
- Last-beat handshake -> DONE. frame_done=1 for that one cycle. Then -> IDLE, busy=0.
- start in any state other than IDLE is ignored; the frame in progress is unaffected.
- dat_tready held low indefinitely: FIFO fills, further samples are dropped and overflow is set. The frame still ends only after FFT_LEN accepted samples are sent, so the core never sees a missing or unexpected tlast.
- Reset asserted mid-frame: immediate return to IDLE; FIFO flushed; dat_tvalid/cfg_tvalid drop asynchronously to 0.
- FFT_LEN counters are $clog2(FFT_LEN)+1 bits wide; no wrap within a frame.

Test Plan:
- Basic frame: FFT_LEN=16, fwd_inv=1, start, cfg_tready=1, dat_tready=1, ad_valid every cycle with ad_data=0..15 -> one cfg beat with tdata 8'h01; 16 data beats with real = 16'hFE00+i; tlast only on beat 16; frame_done one cycle later with busy falling.
- Inverse + cfg stall: fwd_inv=0, cfg_tready low 5 cycles -> cfg_tvalid held with 8'h00; no data beats before cfg handshake; ad_valid during CFG ignored.
- Backpressure: dat_tready toggles 1/0 each cycle, ad_valid 1 of 3 cycles -> no drops, overflow=0; tdata/tlast stable on stalled cycles; exactly 16 beats.
- Overflow: FIFO_DEPTH=4, dat_tready=0 for 10 ad_valid cycles -> 4 samples buffered, overflow=1; after tready=1, frame completes after 16 accepted samples with tlast on 16th beat.
- Boundary conversion: ad_data 10'h3FF, 10'h200, 10'h000 -> real 16'h01FF, 16'h0000, 16'hFE00; imag 0.
- Reset/start abuse: start pulsed during STREAM -> ignored. sys_rst_n low mid-frame -> all outputs 0 immediately; a new start afterwards produces a clean 16-beat frame.
